npu_host_seq: RTL and testbench

NPU_HOST_SEQ -- requirements
Module: npu_host_seq

---
 rtl/npu_host_seq.sv | 125 ++++++++++++
 tb/tb_npu_host_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/npu_host_seq.sv
// npu_host_seq: host-side sequencer driving the NPU register bus.
// Executes WRITE / READ / WAIT / WRITE_WAIT commands, one response each.
module npu_host_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET_X,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_TYPE,
    input  logic [7:0]  CMD_ADR,
    input  logic [31:0] CMD_DATA,
    output logic [7:0]  ADR,
    output logic        WR,
    output logic        RD,
    output logic [31:0] WDATA,
    input  logic [31:0] RDATA,
    input  logic        INT,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RCAP,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] T_READ       = 2'd1;
    localparam logic [1:0] T_WAIT       = 2'd2;
    localparam logic [1:0] T_WRITE_WAIT = 2'd3;

    state_t      state_q;
    logic [1:0]  type_q;
    logic [7:0]  adr_q;
    logic [31:0] data_q;
    logic [15:0] cnt_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    always_ff @(posedge CLK) begin
        if (!RESET_X) begin
            state_q    <= S_IDLE;
            type_q     <= '0;
            adr_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        type_q <= CMD_TYPE;
                        adr_q  <= CMD_ADR;
                        data_q <= CMD_DATA;
                        cnt_q  <= '0;
                        case (CMD_TYPE)
                            T_READ:  state_q <= S_READ;
                            T_WAIT:  state_q <= S_WAIT;
                            default: state_q <= S_WRITE;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (type_q == T_WRITE_WAIT) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end
                end
                S_READ: begin
                    state_q <= S_RCAP;
                end
                S_RCAP: begin
                    rsp_data_q <= RDATA;
                    rsp_err_q  <= 1'b0;
                    state_q    <= S_RESP;
                end
                S_WAIT: begin
                    // INT wins over a coincident timeout
                    if (INT) begin
                        rsp_data_q <= {16'h0, cnt_q};
                        rsp_err_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                        rsp_data_q <= {16'h0, TIMEOUT_CYC};
                        rsp_err_q  <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = (state_q == S_IDLE);
    assign BUSY      = (state_q != S_IDLE);
    assign RSP_VALID = (state_q == S_RESP);
    assign WR        = (state_q == S_WRITE);
    assign RD        = (state_q == S_READ);
    assign ADR       = (WR || RD) ? adr_q : 8'h00;
    assign WDATA     = WR ? data_q : 32'h0;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq: table-driven and randomized checks of npu_host_seq
// against a latency/response model of the command set.
module tb_npu_host_seq;

    localparam int T = 8;

    logic        CLK = 1'b0;
    logic        RESET_X;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE;
    logic [7:0]  CMD_ADR;
    logic [31:0] CMD_DATA;
    logic [7:0]  ADR;
    logic        WR;
    logic        RD;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic        INT;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    npu_host_seq #(.TIMEOUT_CYC(16'd8)) dut (
        .CLK(CLK), .RESET_X(RESET_X),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_ADR(CMD_ADR), .CMD_DATA(CMD_DATA),
        .ADR(ADR), .WR(WR), .RD(RD), .WDATA(WDATA), .RDATA(RDATA),
        .INT(INT), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] resp_val(input logic [7:0] a);
        if (a == 8'hC0) return 32'h0000_00A5;
        return {a, 8'h5A, ~a, 8'h3C};
    endfunction

    // Registered responder; junk on RDATA whenever RD was not asserted
    always @(posedge CLK) begin
        if (RD) RDATA <= resp_val(ADR);
        else    RDATA <= $urandom;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ic: index of the WAIT cycle where INT first rises (-1 = never)
    task automatic model(input logic [1:0] t, input logic [7:0] a,
                         input int ic, output logic [31:0] ed,
                         output logic ee, output int lat);
        bit hit;
        hit = (ic >= 0) && (ic < T);
        ee  = 1'b0;
        case (t)
            2'd0: begin ed = 32'h0; lat = 2; end
            2'd1: begin ed = resp_val(a); lat = 3; end
            default: begin
                ed  = hit ? ic : T;
                ee  = !hit;
                lat = ((t == 2'd2) ? 1 : 2) + (hit ? ic + 1 : T);
            end
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [7:0] a,
                           input logic [31:0] d, input int ic,
                           input int hold, input logic [31:0] ed,
                           input logic ee, input int lat);
        int  ws;
        bit  busy_e;
        bit  in_resp;
        bit  wr_e;
        bit  rd_e;
        ws = (t == 2'd2) ? 1 : 2;
        chk1("ready_before", CMD_READY, 1'b1);
        CMD_VALID = 1'b1;
        CMD_TYPE  = t;
        CMD_ADR   = a;
        CMD_DATA  = d;
        @(posedge CLK);
        #1;
        for (int c = 1; c <= lat + hold + 1; c++) begin
            busy_e    = (c <= lat + hold);
            in_resp   = (c >= lat) && busy_e;
            wr_e      = (c == 1) && (t == 2'd0 || t == 2'd3);
            rd_e      = (c == 1) && (t == 2'd1);
            INT       = (t >= 2'd2) && (ic >= 0) && (c >= ws + ic) && busy_e;
            RSP_READY = (c == lat + hold);
            CMD_VALID = in_resp;
            CMD_TYPE  = 2'($urandom);
            CMD_ADR   = 8'($urandom);
            CMD_DATA  = $urandom;
            chk1("wr", WR, wr_e);
            chk1("rd", RD, rd_e);
            chk("adr", {24'h0, ADR}, (wr_e || rd_e) ? {24'h0, a} : 32'h0);
            chk("wdata", WDATA, wr_e ? d : 32'h0);
            chk1("rsp_valid", RSP_VALID, in_resp);
            chk1("busy", BUSY, busy_e);
            chk1("cmd_ready", CMD_READY, !busy_e);
            if (in_resp) begin
                chk("rsp_data", RSP_DATA, ed);
                chk1("rsp_err", RSP_ERR, ee);
            end
            if (!busy_e) begin
                CMD_VALID = 1'b0;
                INT       = 1'b0;
                RSP_READY = 1'b0;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  a;
        logic [31:0] d;
        int          ic;
        int          hold;
        logic [31:0] ed;
        logic        ee;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [1:0]  rt;
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [31:0] red;
        logic        ree;
        int          ric;
        int          rh;
        int          rlat;

        tbl[0] = '{2'd0, 8'h50, 32'h1234_5678, -1, 0, 32'h0, 1'b0, 2};
        tbl[1] = '{2'd1, 8'hC0, 32'h0, -1, 0, 32'hA5, 1'b0, 3};
        tbl[2] = '{2'd3, 8'h00, 32'h2, 4, 0, 32'd4, 1'b0, 7};
        tbl[3] = '{2'd2, 8'h00, 32'h0, -1, 0, 32'd8, 1'b1, 9};
        tbl[4] = '{2'd2, 8'h00, 32'h0, 7, 0, 32'd7, 1'b0, 9};
        tbl[5] = '{2'd2, 8'h00, 32'h0, 0, 0, 32'd0, 1'b0, 2};
        tbl[6] = '{2'd0, 8'h33, 32'hCAFE_F00D, -1, 10, 32'h0, 1'b0, 2};
        tbl[7] = '{2'd1, 8'hC0, 32'h0, -1, 10, 32'hA5, 1'b0, 3};

        RESET_X   = 1'b0;
        CMD_VALID = 1'b0;
        CMD_TYPE  = 2'd0;
        CMD_ADR   = 8'h0;
        CMD_DATA  = 32'h0;
        INT       = 1'b0;
        RSP_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk1("rst_cmd_ready", CMD_READY, 1'b1);
        chk1("rst_wr", WR, 1'b0);
        chk1("rst_rd", RD, 1'b0);
        chk("rst_adr", {24'h0, ADR}, 32'h0);
        chk("rst_wdata", WDATA, 32'h0);
        chk1("rst_rsp_valid", RSP_VALID, 1'b0);
        chk1("rst_busy", BUSY, 1'b0);
        chk("rst_rsp_data", RSP_DATA, 32'h0);
        chk1("rst_rsp_err", RSP_ERR, 1'b0);
        RESET_X = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].ic, tbl[i].hold,
                    tbl[i].ed, tbl[i].ee, tbl[i].lat);
        end

        // Reset mid-WAIT: operation abandoned, no response afterwards
        CMD_VALID = 1'b1;
        CMD_TYPE  = 2'd2;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk1("mid_wait_busy", BUSY, 1'b1);
        RESET_X = 1'b0;
        @(posedge CLK);
        #1;
        RESET_X = 1'b1;
        chk1("rstw_cmd_ready", CMD_READY, 1'b1);
        chk1("rstw_rsp_valid", RSP_VALID, 1'b0);
        chk1("rstw_busy", BUSY, 1'b0);
        for (int c = 0; c < 12; c++) begin
            INT = (c >= 2) && (c < 6);
            @(posedge CLK);
            #1;
            chk1("rstw_no_rsp", RSP_VALID, 1'b0);
            chk1("rstw_no_strobe", WR | RD, 1'b0);
            chk1("rstw_idle", BUSY, 1'b0);
        end
        INT = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rt  = 2'($urandom);
            ra  = 8'($urandom);
            rd  = $urandom;
            ric = int'($urandom_range(0, 10)) - 1;
            rh  = int'($urandom_range(0, 3));
            model(rt, ra, ric, red, ree, rlat);
            run_cmd(rt, ra, rd, ric, rh, red, ree, rlat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
